// File: rtl/product_accumulator.sv
// Purpose : sums a programmed number of 16-bit multiplier products into a wide accumulator (MAC / dot-product stage).
// Latency : out_valid rises on the edge that accepts the last product; a zero-term run shows out_valid one cycle after start.
// Backpressure: in_ready is high only while accumulating; the result is held in DONE until out_ready is high.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN: clamp to all ones on carry-out instead of wrapping.
module product_accumulator #(
   parameter int PROD_W  = 16,
   parameter int ACC_W   = 24,   // must be >= PROD_W
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] num_terms,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PROD_W-1:0]  in_product,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic               overflow,
   output logic               busy
);

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_accum = 2'd1,
      st_done  = 2'd2
   } state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [COUNT_W-1:0] remaining;
   logic [ACC_W:0]     sum_ext;
   logic               carry;
   logic [ACC_W-1:0]   acc_next;

   // One extra bit on the adder exposes the carry-out used for overflow detection.
   assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
   assign carry   = sum_ext[ACC_W];

   // Next accumulator value for an accepted beat: clamp or wrap on carry-out.
   always_comb begin
      acc_next = sum_ext[ACC_W-1:0];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      // Once clamped the run stays pinned at all ones.
      if (carry || overflow) begin
         acc_next = {ACC_W{1'b1}};
      end
`endif
   end

   // The result comes straight from the accumulator register, never from in_product.
   assign out_sum = acc;

   // Control FSM with registered handshake outputs and the accumulator datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= st_idle;
         acc       <= '0;
         remaining <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            st_idle: begin
               if (start) begin
                  acc       <= '0;
                  overflow  <= 1'b0;
                  remaining <= num_terms;
                  busy      <= 1'b1;
                  if (num_terms == '0) begin
                     // Nothing to sum: present a zero result right away.
                     state     <= st_done;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                  end else begin
                     state     <= st_accum;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                  end
               end
            end
            st_accum: begin
               // in_ready is high throughout this state, so in_valid alone marks a beat.
               if (in_valid) begin
                  acc       <= acc_next;
                  overflow  <= overflow | carry;
                  remaining <= remaining - 1'b1;
                  if (remaining == COUNT_W'(1)) begin
                     state     <= st_done;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            st_done: begin
               // acc and overflow are left alone so the result survives into IDLE.
               if (out_ready) begin
                  state     <= st_idle;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= st_idle;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Purpose : directed checks of product_accumulator at ACC_W=24 and at ACC_W=17 for overflow.
// Latency : inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Backpressure: out_ready is held low for several cycles to confirm the result is held.
module tb_product_accumulator;

   logic        clk;
   logic        rst_n;

   // 24-bit accumulator instance
   logic        start;
   logic [7:0]  num_terms;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_product;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_sum;
   logic        overflow;
   logic        busy;

   // 17-bit accumulator instance for the overflow case
   logic        s17_start;
   logic [7:0]  s17_num_terms;
   logic        s17_in_valid;
   logic        s17_in_ready;
   logic [15:0] s17_in_product;
   logic        s17_out_valid;
   logic        s17_out_ready;
   logic [16:0] s17_out_sum;
   logic        s17_overflow;
   logic        s17_busy;

   int vectors;
   int miscompares;

   product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_terms  (num_terms),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .overflow   (overflow),
      .busy       (busy)
   );

   product_accumulator #(.PROD_W(16), .ACC_W(17), .COUNT_W(8)) dut17 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (s17_start),
      .num_terms  (s17_num_terms),
      .in_valid   (s17_in_valid),
      .in_ready   (s17_in_ready),
      .in_product (s17_in_product),
      .out_valid  (s17_out_valid),
      .out_ready  (s17_out_ready),
      .out_sum    (s17_out_sum),
      .overflow   (s17_overflow),
      .busy       (s17_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      start          = 1'b0;
      num_terms      = 8'd0;
      in_valid       = 1'b0;
      in_product     = 16'h0;
      out_ready      = 1'b1;
      s17_start      = 1'b0;
      s17_num_terms  = 8'd0;
      s17_in_valid   = 1'b0;
      s17_in_product = 16'h0;
      s17_out_ready  = 1'b1;

      // ---- reset state ----
      #3;
      check("rst_in_ready",  32'(in_ready),  32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_sum",   32'(out_sum),   32'h0);
      check("rst_overflow",  32'(overflow),  32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // ---- basic run: 3 x 0xFE01 = 0x2FA03 ----
      start = 1'b1; num_terms = 8'd3;
      tick();
      start = 1'b0;
      check("t1_in_ready_accum", 32'(in_ready), 32'h1);
      check("t1_busy_accum",     32'(busy),     32'h1);
      in_valid = 1'b1; in_product = 16'hFE01;
      tick();
      tick();
      check("t1_out_valid_early", 32'(out_valid), 32'h0);
      tick();
      in_valid = 1'b0;
      check("t1_out_valid",  32'(out_valid), 32'h1);
      check("t1_out_sum",    32'(out_sum),   32'h02FA03);
      check("t1_overflow",   32'(overflow),  32'h0);
      check("t1_in_ready_done", 32'(in_ready), 32'h0);
      tick();
      check("t1_out_valid_idle", 32'(out_valid), 32'h0);
      check("t1_busy_idle",      32'(busy),      32'h0);
      check("t1_sum_kept",       32'(out_sum),   32'h02FA03);

      // ---- input gaps and output back-pressure ----
      out_ready = 1'b0;
      start = 1'b1; num_terms = 8'd2;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_product = 16'h0010;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_in_ready_gap", 32'(in_ready),  32'h1);
         check("t2_no_valid_gap", 32'(out_valid), 32'h0);
         tick();
      end
      check("t2_sum_partial", 32'(out_sum), 32'h000010);
      in_valid = 1'b1; in_product = 16'h0020;
      tick();
      in_valid = 1'b0;
      check("t2_in_ready_done", 32'(in_ready), 32'h0);
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", 32'(out_valid), 32'h1);
         check("t2_hold_sum",   32'(out_sum),   32'h000030);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("t2_idle_valid", 32'(out_valid), 32'h0);
      check("t2_idle_busy",  32'(busy),      32'h0);

      // ---- zero terms ----
      out_ready = 1'b0;
      start = 1'b1; num_terms = 8'd0;
      tick();
      start = 1'b0;
      check("t3_out_valid", 32'(out_valid), 32'h1);
      check("t3_out_sum",   32'(out_sum),   32'h0);
      check("t3_in_ready",  32'(in_ready),  32'h0);
      check("t3_busy",      32'(busy),      32'h1);
      out_ready = 1'b1;
      tick();
      check("t3_idle_valid", 32'(out_valid), 32'h0);
      check("t3_idle_ready", 32'(in_ready),  32'h0);

      // ---- overflow on the 17-bit instance: 0x2FA03 does not fit ----
      s17_start = 1'b1; s17_num_terms = 8'd3;
      tick();
      s17_start = 1'b0;
      s17_in_valid = 1'b1; s17_in_product = 16'hFE01;
      tick();
      tick();
      check("t4_no_overflow_yet", 32'(s17_overflow), 32'h0);
      check("t4_sum_two",         32'(s17_out_sum),  32'h1FC02);
      tick();
      s17_in_valid = 1'b0;
      check("t4_out_valid", 32'(s17_out_valid), 32'h1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      check("t4_out_sum",   32'(s17_out_sum),   32'h1FFFF);
`else
      check("t4_out_sum",   32'(s17_out_sum),   32'h0FA03);
`endif
      check("t4_overflow",  32'(s17_overflow),  32'h1);
      tick();
      check("t4_idle_valid",    32'(s17_out_valid), 32'h0);
      check("t4_overflow_kept", 32'(s17_overflow),  32'h1);
      s17_start = 1'b1; s17_num_terms = 8'd0;
      tick();
      s17_start = 1'b0;
      check("t4_overflow_cleared", 32'(s17_overflow), 32'h0);
      tick();

      // ---- reset mid-run ----
      start = 1'b1; num_terms = 8'd4;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_product = 16'h0100;
      tick();
      tick();
      in_valid = 1'b0;
      check("t5_partial_sum", 32'(out_sum), 32'h000200);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_in_ready",  32'(in_ready),  32'h0);
      check("t5_rst_busy",      32'(busy),      32'h0);
      check("t5_rst_out_sum",   32'(out_sum),   32'h0);
      check("t5_rst_out_valid", 32'(out_valid), 32'h0);
      check("t5_rst_overflow",  32'(overflow),  32'h0);
      #1;
      rst_n = 1'b1;
      tick();
      check("t5_idle_after_rst", 32'(in_ready), 32'h0);
      start = 1'b1; num_terms = 8'd1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_product = 16'h0005;
      tick();
      in_valid = 1'b0;
      check("t5_out_valid", 32'(out_valid), 32'h1);
      check("t5_out_sum",   32'(out_sum),   32'h000005);
      check("t5_overflow",  32'(overflow),  32'h0);
      tick();

      // ---- start ignored while busy ----
      start = 1'b1; num_terms = 8'd2;
      tick();
      num_terms = 8'd9;
      in_valid = 1'b1; in_product = 16'h0007;
      tick();
      check("t6_accum_ready", 32'(in_ready), 32'h1);
      check("t6_accum_sum",   32'(out_sum),  32'h000007);
      in_product = 16'h0008;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("t6_done_valid", 32'(out_valid), 32'h1);
      check("t6_done_sum",   32'(out_sum),   32'h00000F);
      tick();
      check("t6_hold_valid", 32'(out_valid), 32'h1);
      check("t6_hold_sum",   32'(out_sum),   32'h00000F);
      check("t6_hold_ready", 32'(in_ready),  32'h0);
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t6_idle_busy",  32'(busy),      32'h0);
      check("t6_idle_valid", 32'(out_valid), 32'h0);
      tick();
      check("t6_stays_idle", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 byte multiplier.
- Consumes a stream of 16-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Returns the sum through a valid/ready output handshake.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PROD_W, 16, width of each incoming product (matches multiplier output).
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- COUNT_W, 8, width of the term counter; up to 2^COUNT_W-1 terms per run.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- num_terms  input  COUNT_W  number of products to sum; sampled with start
- in_valid  input  1  in_product is valid
- in_ready  output  1  block accepts a product this cycle
- in_product  input  PROD_W  product from multiplier, unsigned
- out_valid  output  1  out_sum is valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  accumulated sum
- overflow  output  1  sticky: run exceeded ACC_W range
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk.
- Asserting rst_n low, at any time including mid-run, forces the following immediately:
  - state IDLE
  - acc = 0, remaining = 0
  - in_ready = 0, out_valid = 0, out_sum = 0, overflow = 0, busy = 0
- A partial sum is discarded on reset.
- Registered state machine with three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start = 1 with num_terms = 0: go to DONE with acc = 0 and overflow = 0.
  - start = 1 with num_terms > 0: acc = 0, overflow = 0, remaining = num_terms, go to ACCUM.
- ACCUM:
  - in_ready = 1; start is ignored.
  - A beat is accepted when in_valid && in_ready: acc <= acc + zero_extend(in_product), remaining <= remaining - 1.
  - When a beat is accepted with remaining == 1, go to DONE.
  - Cycles with in_valid = 0 leave all state unchanged.
- DONE:
  - out_valid = 1, in_ready = 0; start is ignored.
  - out_sum and overflow are held stable while out_ready = 0.
  - out_ready = 1: go to IDLE on the next edge. out_sum keeps its last value and overflow stays set until the next start.
- Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible in the following cycle. A zero-term run reaches out_valid one cycle after start.
- Throughput: one product per cycle in ACCUM.
- out_sum is driven from the acc register; no combinational path from in_product to out_sum.
- Overflow: if the ACC_W+1-bit sum of acc and the product carries out, overflow is set and stays set for the rest of the run.

Optional Feature:
- Macro name: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: on carry-out, acc is clamped to all ones (2^ACC_W-1) and stays there for the rest of the run; overflow is set.
- Not defined: acc wraps modulo 2^ACC_W; overflow is still set.
- Handshake and timing are identical in both builds.

Test Plan:
- Basic run, defaults: start with num_terms = 3, then products 0xFE01, 0xFE01, 0xFE01 on consecutive cycles with out_ready = 1 -> out_valid for one cycle, out_sum = 0x02FA03, overflow = 0, then back to IDLE.
- Input gaps and output back-pressure: num_terms = 2, products 0x0010 and 0x0020 separated by 3 idle cycles, out_ready = 0 for 5 cycles -> in_ready stays high until the 2nd beat; out_valid is held with out_sum = 0x000030 unchanged; IDLE is entered on the cycle after out_ready = 1.
- Zero terms: start with num_terms = 0 -> out_valid the next cycle, out_sum = 0, no beats accepted (in_ready never high).
- Overflow with ACC_W = 17: three beats of 0xFE01 -> without the macro, out_sum = 0x0FA03 and overflow = 1; with PRODUCT_ACCUMULATOR_SATURATE_EN defined, out_sum = 0x1FFFF and overflow = 1.
- Reset mid-run: num_terms = 4, 2 beats accepted, then rst_n pulsed low between clock edges -> outputs clear asynchronously; a new run with num_terms = 1 and product 0x0005 -> out_sum = 0x000005, overflow = 0.
- Start ignored while busy: pulse start with num_terms = 9 during ACCUM and again during DONE -> the run completes with the original term count and the correct sum.
